// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run-control sequencer for the 16-bit 5-stage pipelined core. It turns the
// external start/enable controls into the core's pipeline-advance enables and
// a one-cycle PC/pipeline clear. It also provides these functions:
//   - pause, resume and single-step;
//   - HALT-driven pipeline drain;
//   - an optional PC breakpoint;
//   - a saturating executed-cycle counter.
//
// Optional feature macro: CPU_RUN_CTRL_BREAKPOINT_EN
//   - Defined: the PC breakpoint comparator and the sticky bp_hit flag are
//     built.
//   - Undefined: pc, bp_addr and bp_valid are ignored and bp_hit is tied to 0.
//
// Parameters
//   CNT_W         width of cycle_cnt
//   DRAIN_CYCLES  cycles the back end keeps running after HALT decode (1..15)
//
// Ports
//   clk        in   system clock, rising edge
//   r_st       in   asynchronous active-high reset
//   enable     in   master enable; 0 freezes state and gates the core enables
//   start      in   start / restart / resume request (level)
//   pause_req  in   pause request, honoured in RUN only
//   step       in   single-step request, honoured in PAUSE only
//   halt_op    in   ID stage holds a HALT opcode
//   pc         in   IF-stage PC
//   bp_addr    in   breakpoint address
//   bp_valid   in   breakpoint armed
//   fetch_en   out  IF may fetch and advance pc
//   core_en    out  ID/EX/MEM/WB registers may advance
//   pc_clr     out  one-cycle PC and pipeline clear
//   running    out  state is RUN or STEP
//   halted     out  state is HALTED
//   bp_hit     out  sticky breakpoint-pause flag
//   cycle_cnt  out  saturating count of cycles with core_en=1
//   state      out  encoded state (IDLE=0 .. HALTED=6)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             r_st,
    input  logic             enable,
    input  logic             start,
    input  logic             pause_req,
    input  logic             step,
    input  logic             halt_op,
    input  logic [15:0]      pc,
    input  logic [15:0]      bp_addr,
    input  logic             bp_valid,
    output logic             fetch_en,
    output logic             core_en,
    output logic             pc_clr,
    output logic             running,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRestart = 3'd1,
        StRun     = 3'd2,
        StPause   = 3'd3,
        StStep    = 3'd4,
        StDrain   = 3'd5,
        StHalted  = 3'd6
    } state_e;

    // The drain counter is loaded on DRAIN entry, so DRAIN lasts DRAIN_CYCLES cycles.
    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e     state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       bp_match;
    logic       bp_set;
    logic       bp_clr;

    // -----------------------------------------------------------------------
    // Breakpoint comparator
    // -----------------------------------------------------------------------
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // fetch_en qualifies the match: the instruction at bp_addr must really be
    // fetched this cycle, so it sits in IF/ID once the pause takes effect.
    assign bp_match = bp_valid && (pc == bp_addr) && fetch_en;
`else
    assign bp_match = 1'b0;

    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid, bp_set, bp_clr};
`endif

    // -----------------------------------------------------------------------
    // Next-state logic. The whole sequencer is frozen while enable is low.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        bp_set  = 1'b0;
        bp_clr  = 1'b0;

        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_d = StRestart;
                end
                StRestart: begin
                    state_d = StRun;
                end
                StRun: begin
                    // HALT beats a breakpoint on the same cycle.
                    if (halt_op) begin
                        state_d = StDrain;
                        drain_d = DrainLoad;
                    end else if (bp_match) begin
                        state_d = StPause;
                        bp_set  = 1'b1;
                    end else if (pause_req) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (start) begin
                        state_d = StRun;
                        bp_clr  = 1'b1;
                    end else if (step) begin
                        state_d = StStep;
                    end
                end
                StStep: begin
                    if (halt_op) begin
                        state_d = StDrain;
                        drain_d = DrainLoad;
                    end else begin
                        state_d = StPause;
                    end
                end
                StDrain: begin
                    if (drain_q == 4'd0) begin
                        state_d = StHalted;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                StHalted: begin
                    if (start) state_d = StRestart;
                end
                default: begin
                    state_d = StIdle;
                    drain_d = 4'd0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and registered outputs. The outputs are decoded from state_d so
    // that they line up with the new state in the cycle after the edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            state_q   <= StIdle;
            drain_q   <= 4'd0;
            fetch_en  <= 1'b0;
            core_en   <= 1'b0;
            pc_clr    <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            fetch_en <= enable && (state_d == StRun || state_d == StStep);
            core_en  <= enable && (state_d == StRun || state_d == StStep ||
                                   state_d == StDrain);
            pc_clr   <= enable && (state_d == StRestart);
            running  <= (state_d == StRun) || (state_d == StStep);
            halted   <= (state_d == StHalted);

            // core_en here is the value for the cycle ending at this edge.
            if (enable) begin
                if (state_d == StRestart) begin
                    cycle_cnt <= '0;
                end else if (core_en && (cycle_cnt != '1)) begin
                    cycle_cnt <= cycle_cnt + CntOne;
                end
            end
        end
    end

    assign state = state_q;

    // -----------------------------------------------------------------------
    // Sticky breakpoint flag
    // -----------------------------------------------------------------------
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic bp_hit_q;

    always_ff @(posedge clk or posedge r_st) begin
        if (r_st) begin
            bp_hit_q <= 1'b0;
        end else if (enable) begin
            if (state_d == StRestart || bp_clr) begin
                bp_hit_q <= 1'b0;
            end else if (bp_set) begin
                bp_hit_q <= 1'b1;
            end
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Self-checking bench for cpu_run_ctrl. It contains two DUTs that share all
// inputs:
//   - u_dut uses the default parameters (CNT_W=16, DRAIN_CYCLES=3);
//   - u_sat uses CNT_W=4 and is used for the counter-saturation checks.
// Breakpoint expectations follow CPU_RUN_CTRL_BREAKPOINT_EN.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r_st;
    logic        enable, start, pause_req, step, halt_op, bp_valid;
    logic [15:0] pc, bp_addr;

    logic        fetch_en, core_en, pc_clr, running, halted, bp_hit;
    logic [15:0] cycle_cnt;
    logic [2:0]  state;

    logic        s_fetch_en, s_core_en, s_pc_clr, s_running, s_halted, s_bp_hit;
    logic [3:0]  s_cycle_cnt;
    logic [2:0]  s_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl u_dut (
        .clk       (clk),
        .r_st      (r_st),
        .enable    (enable),
        .start     (start),
        .pause_req (pause_req),
        .step      (step),
        .halt_op   (halt_op),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .fetch_en  (fetch_en),
        .core_en   (core_en),
        .pc_clr    (pc_clr),
        .running   (running),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .cycle_cnt (cycle_cnt),
        .state     (state)
    );

    cpu_run_ctrl #(
        .CNT_W        (4),
        .DRAIN_CYCLES (3)
    ) u_sat (
        .clk       (clk),
        .r_st      (r_st),
        .enable    (enable),
        .start     (start),
        .pause_req (pause_req),
        .step      (step),
        .halt_op   (halt_op),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .fetch_en  (s_fetch_en),
        .core_en   (s_core_en),
        .pc_clr    (s_pc_clr),
        .running   (s_running),
        .halted    (s_halted),
        .bp_hit    (s_bp_hit),
        .cycle_cnt (s_cycle_cnt),
        .state     (s_state)
    );

    typedef struct packed {
        logic        en, st, pr, sp, ht;
        logic [2:0]  e_st;
        logic        e_fe, e_ce, e_clr, e_run, e_hlt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [31];

    function automatic vec_t mk(input bit en, st, pr, sp, ht, input int est,
                                input bit fe, ce, clr, run, hlt, input int cnt);
        vec_t v;
        v.en = en; v.st = st; v.pr = pr; v.sp = sp; v.ht = ht;
        v.e_st = 3'(est); v.e_fe = fe; v.e_ce = ce; v.e_clr = clr;
        v.e_run = run; v.e_hlt = hlt; v.e_cnt = 16'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int est, input bit fe, ce, clr, run,
                           hlt, bph, input int cnt);
        chk({tag, ".state"},     32'(state),     32'(est));
        chk({tag, ".fetch_en"},  32'(fetch_en),  32'(fe));
        chk({tag, ".core_en"},   32'(core_en),   32'(ce));
        chk({tag, ".pc_clr"},    32'(pc_clr),    32'(clr));
        chk({tag, ".running"},   32'(running),   32'(run));
        chk({tag, ".halted"},    32'(halted),    32'(hlt));
        chk({tag, ".bp_hit"},    32'(bp_hit),    32'(bph));
        chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(cnt));
    endtask

    task automatic drive(input bit en, st, pr, sp, ht, input logic [15:0] pcv, input bit bv);
        enable = en; start = st; pause_req = pr; step = sp; halt_op = ht;
        pc = pcv; bp_valid = bv;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        int base;

        // Stimulus table: en st pr sp ht | state fe ce clr run hlt cnt
        vecs[0]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);  // start -> RESTART
        vecs[1]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 0);  // -> RUN
        vecs[2]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 1);
        vecs[3]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 2);
        vecs[4]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 3);
        vecs[5]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 4);
        vecs[6]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 5);  // 5 RUN cycles counted
        vecs[7]  = mk(1, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 6);  // pause
        vecs[8]  = mk(1, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 6);  // pause_req in PAUSE ignored
        vecs[9]  = mk(1, 0, 0, 1, 0, 4, 1, 1, 0, 1, 0, 6);  // step 1
        vecs[10] = mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 7);
        vecs[11] = mk(1, 0, 0, 1, 0, 4, 1, 1, 0, 1, 0, 7);  // step 2
        vecs[12] = mk(1, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 8);  // STEP lasts one cycle
        vecs[13] = mk(1, 0, 0, 1, 0, 4, 1, 1, 0, 1, 0, 8);  // step 3
        vecs[14] = mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 9);
        vecs[15] = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 1, 0, 9);  // start beats step
        vecs[16] = mk(1, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 10); // HALT -> DRAIN
        vecs[17] = mk(1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 11);
        vecs[18] = mk(1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 12);
        vecs[19] = mk(1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 1, 13); // HALTED
        vecs[20] = mk(1, 0, 1, 1, 0, 6, 0, 0, 0, 0, 1, 13); // requests ignored
        vecs[21] = mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);  // restart clears count
        vecs[22] = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 0);
        vecs[23] = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 1);
        vecs[24] = mk(0, 1, 0, 1, 0, 2, 0, 0, 0, 1, 0, 1);  // enable low: frozen
        vecs[25] = mk(0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0, 1);
        vecs[26] = mk(0, 1, 0, 0, 1, 2, 0, 0, 0, 1, 0, 1);  // halt ignored too
        vecs[27] = mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 1, 0, 1);
        vecs[28] = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 1);  // re-enabled
        vecs[29] = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0, 2);
        vecs[30] = mk(1, 0, 0, 1, 0, 2, 1, 1, 0, 1, 0, 3);  // step in RUN ignored

        bp_addr = 16'h0004;
        drive(0, 0, 0, 0, 0, 16'h0000, 0);
        r_st = 1'b1;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.sat_cnt", 32'(s_cycle_cnt), 32'd0);
        r_st = 1'b0;
        tick();
        chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].en, vecs[i].st, vecs[i].pr, vecs[i].sp, vecs[i].ht, 16'h0000, 0);
            tick();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].e_st), vecs[i].e_fe, vecs[i].e_ce,
                    vecs[i].e_clr, vecs[i].e_run, vecs[i].e_hlt, 1'b0, int'(vecs[i].e_cnt));
        end

        // Breakpoint at 0x0004 while in RUN (cycle_cnt = 3 here).
        drive(1, 0, 0, 0, 0, 16'h0003, 1);
        tick();
        chk_all("bp_a", 2, 1, 1, 0, 1, 0, 0, 4);
        drive(1, 0, 0, 0, 0, 16'h0004, 1);
        tick();
        chk_all("bp_b", BP ? 3 : 2, !BP, !BP, 0, !BP, 0, BP, 5);
        drive(1, 0, 0, 0, 0, 16'h0005, 1);
        tick();
        chk_all("bp_c", BP ? 3 : 2, !BP, !BP, 0, !BP, 0, BP, BP ? 5 : 6);
        drive(1, 1, 0, 0, 0, 16'h0005, 1);
        tick();
        chk_all("bp_resume", 2, 1, 1, 0, 1, 0, 0, BP ? 5 : 7);
        // HALT and a breakpoint match together: DRAIN wins, no bp_hit.
        base = BP ? 6 : 8;
        drive(1, 0, 0, 0, 1, 16'h0004, 1);
        tick();
        chk_all("bp_halt", 5, 0, 1, 0, 0, 0, 0, base);
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        tick();
        chk_all("bp_drain1", 5, 0, 1, 0, 0, 0, 0, base + 1);
        tick();
        chk_all("bp_drain2", 5, 0, 1, 0, 0, 0, 0, base + 2);
        tick();
        chk_all("bp_halted", 6, 0, 0, 0, 0, 1, 0, base + 3);

        // Saturation on the 4-bit counter over 20 RUN cycles.
        drive(1, 1, 0, 0, 0, 16'h0000, 0);
        tick();
        chk_all("sat_restart", 1, 0, 0, 1, 0, 0, 0, 0);
        chk("sat_restart.sat_cnt", 32'(s_cycle_cnt), 32'd0);
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        tick();
        chk_all("sat_run", 2, 1, 1, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_k%0d.sat_cnt", k), 32'(s_cycle_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        chk("sat_main_cnt", 32'(cycle_cnt), 32'd20);

        // Asynchronous reset in the middle of DRAIN.
        drive(1, 0, 0, 0, 1, 16'h0000, 0);
        tick();
        chk("mid_drain.state", 32'(state), 32'd5);
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        tick();
        #2;
        r_st = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("async_reset.sat_cnt", 32'(s_cycle_cnt), 32'd0);
        chk("async_reset.sat_state", 32'(s_state), 32'd0);
        tick();
        r_st = 1'b0;
        tick();
        chk_all("after_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Full drain after the reset: the drain counter must reload cleanly.
        drive(1, 1, 0, 0, 0, 16'h0000, 0);
        tick();
        chk_all("rd_restart", 1, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        tick();
        chk_all("rd_run", 2, 1, 1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 16'h0000, 0);
        tick();
        chk_all("rd_drain0", 5, 0, 1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        tick();
        chk_all("rd_drain1", 5, 0, 1, 0, 0, 0, 0, 2);
        tick();
        chk_all("rd_drain2", 5, 0, 1, 0, 0, 0, 0, 3);
        tick();
        chk_all("rd_halted", 6, 0, 0, 0, 0, 1, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
